// File: rtl/sram_data_responder_pkg.sv
// Shared constants for the data-SRAM responder: MMIO offsets, window bases,
// the read-source select encoding and a byte-lane merge helper.
package sram_data_responder_pkg;

   localparam logic [15:0] LED_OFF    = 16'h8000;
   localparam logic [15:0] SWITCH_OFF = 16'h8004;
   localparam logic [15:0] NUM_OFF    = 16'h8010;
   localparam logic [15:0] TIMER_OFF  = 16'he000;

   localparam logic [31:0] CONF_BASE_DEF = 32'hbfaf_0000;
   localparam logic [31:0] RAM_BASE_DEF  = 32'h1c00_0000;

   // Source of data_sram_rdata, captured with each accepted request.
   typedef enum logic [1:0] {
      RSEL_ZERO = 2'd0,
      RSEL_RAM  = 2'd1,
      RSEL_REG  = 2'd2
   } rsel_e;

   // Replace the byte lanes of old_word whose strobe is set with those of new_word.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  we);
      logic [31:0] res;
      res = old_word;
      for (int i = 0; i < 4; i++) begin
         if (we[i]) res[8*i +: 8] = new_word[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/sram_bytewe_ram.sv
// Word-addressed 32-bit RAM with per-byte write enables and a registered,
// read-first output (returns the pre-write word on a write cycle).
module sram_bytewe_ram #(
   parameter int AW = 16
) (
   input  logic          clk,
   input  logic          en,
   input  logic [3:0]    we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [2**AW];

   // Read old word and merge strobed byte lanes on every enabled cycle.
   // NOTE: the storage array has no reset; only control state is reset, which keeps this a plain block RAM.
   always_ff @(posedge clk) begin
      if (en) begin
         // NOTE: non-blocking assignments here make the read see the pre-write word (read-first).
         rdata <= mem[addr];
         for (int i = 0; i < 4; i++) begin
            if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

endmodule

// File: rtl/sram_data_responder.sv
// Responder end of the core's data-SRAM port: RAM window plus MMIO window
// (LED, SWITCH, NUM, TIMER), 1-cycle read latency, read-first writes.
module sram_data_responder
   import sram_data_responder_pkg::*;
#(
   parameter int          RAM_AW    = 16,
   parameter logic [31:0] CONF_BASE = CONF_BASE_DEF,
   parameter logic [31:0] RAM_BASE  = RAM_BASE_DEF
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_we,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   input  logic [7:0]  switch_in,
   output logic [15:0] led_out,
   output logic [31:0] num_out
);

   logic        ram_hit, conf_hit, is_wr;
   logic [13:0] off_w;
   logic        sel_led, sel_switch, sel_num, sel_timer;
   logic [31:0] timer;
   logic [31:0] reg_rd, reg_q, ram_q;
   rsel_e       rsel;
   logic        unused_addr_lsbs;

   // Word access: the two byte-offset bits play no part in decode.
   assign unused_addr_lsbs = ^data_sram_addr[1:0];

   assign ram_hit  = data_sram_addr[31:RAM_AW+2] == RAM_BASE[31:RAM_AW+2];
   assign conf_hit = data_sram_addr[31:16] == CONF_BASE[31:16];
   assign is_wr    = |data_sram_we;
   assign off_w    = data_sram_addr[15:2];

   assign sel_led    = conf_hit && off_w == LED_OFF[15:2];
   assign sel_switch = conf_hit && off_w == SWITCH_OFF[15:2];
   assign sel_num    = conf_hit && off_w == NUM_OFF[15:2];
   assign sel_timer  = conf_hit && off_w == TIMER_OFF[15:2];

   // Reset blocks the RAM so a request issued during reset is dropped.
   sram_bytewe_ram #(.AW(RAM_AW)) u_ram (
      .clk   (clk),
      .en    (resetn && data_sram_en && ram_hit),
      .we    (data_sram_we),
      .addr  (data_sram_addr[RAM_AW+1:2]),
      .wdata (data_sram_wdata),
      .rdata (ram_q)
   );

   // MMIO read value at the request cycle (before this edge's updates).
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      reg_rd = '0;
      if (sel_led)    reg_rd = {16'h0, led_out};
      if (sel_switch) reg_rd = {24'h0, switch_in};
      if (sel_num)    reg_rd = num_out;
      if (sel_timer)  reg_rd = timer;
   end

   // LED and NUM registers with byte-strobed writes.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         led_out <= '0;
         num_out <= '0;
      end else if (data_sram_en && is_wr) begin
         if (sel_led) begin
            if (data_sram_we[0]) led_out[7:0]  <= data_sram_wdata[7:0];
            if (data_sram_we[1]) led_out[15:8] <= data_sram_wdata[15:8];
         end
         if (sel_num) num_out <= merge_bytes(num_out, data_sram_wdata, data_sram_we);
      end
   end

   // Free-running cycle timer; a write loads the merged value instead of counting.
   always_ff @(posedge clk) begin
      if (!resetn)
         timer <= '0;
      else if (data_sram_en && is_wr && sel_timer)
         timer <= merge_bytes(timer, data_sram_wdata, data_sram_we);
      else
         timer <= timer + 32'd1;
   end

   // Capture read source and MMIO read data with each accepted request; hold otherwise.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         rsel  <= RSEL_ZERO;
         reg_q <= '0;
      end else if (data_sram_en) begin
         rsel  <= ram_hit ? RSEL_RAM : (conf_hit ? RSEL_REG : RSEL_ZERO);
         reg_q <= reg_rd;
      end
   end

   // Output mux driven by the registered select.
   always_comb begin
      data_sram_rdata = '0;
      case (rsel)
         RSEL_RAM: data_sram_rdata = ram_q;
         RSEL_REG: data_sram_rdata = reg_q;
         default:  data_sram_rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_sram_data_responder.sv
// Directed self-checking bench for sram_data_responder.
module tb_sram_data_responder;
   import sram_data_responder_pkg::*;

   logic        clk = 1'b0;
   logic        resetn;
   logic        en;
   logic [3:0]  we;
   logic [31:0] addr, wdata;
   logic [31:0] rdata;
   logic [7:0]  switch_in;
   logic [15:0] led_out;
   logic [31:0] num_out;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [31:0] A_LED   = CONF_BASE_DEF + 32'h8000;
   localparam logic [31:0] A_SW    = CONF_BASE_DEF + 32'h8004;
   localparam logic [31:0] A_NUM   = CONF_BASE_DEF + 32'h8010;
   localparam logic [31:0] A_TIMER = CONF_BASE_DEF + 32'he000;
   localparam logic [31:0] A_M     = 32'h1c00_0010;
   localparam logic [31:0] A_A     = 32'h1c00_0020;
   localparam logic [31:0] A_B     = 32'h1c00_0024;

   sram_data_responder dut (
      .clk             (clk),
      .resetn          (resetn),
      .data_sram_en    (en),
      .data_sram_we    (we),
      .data_sram_addr  (addr),
      .data_sram_wdata (wdata),
      .data_sram_rdata (rdata),
      .switch_in       (switch_in),
      .led_out         (led_out),
      .num_out         (num_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one cycle's request, step past the edge, leave outputs ready to sample.
   task automatic cyc(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
      en = e; we = w; addr = a; wdata = d;
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [31:0] a);
      cyc(1'b1, 4'h0, a, 32'h0);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
      cyc(1'b1, w, a, d);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 4'hf, 32'h0, 32'hffff_ffff);
   endtask

   logic [31:0] t0;

   initial begin
      resetn = 1'b0; en = 1'b0; we = '0; addr = '0; wdata = '0; switch_in = 8'h00;
      #1;
      idle(3);
      check("reset_rdata", rdata, 32'h0);
      check("reset_led", {16'h0, led_out}, 32'h0);
      check("reset_num", num_out, 32'h0);
      resetn = 1'b1;
      rd(A_TIMER);
      check("timer_after_reset", rdata, 32'h0);

      // RAM byte merge
      wr(A_M, 32'h1122_3344, 4'hf);
      wr(A_M, 32'haabb_ccdd, 4'b0101);
      check("ram_readfirst_merge", rdata, 32'h1122_3344);
      rd(A_M);
      check("ram_merge", rdata, 32'h11bb_33dd);

      // Read-first and back-to-back reads
      wr(A_A, 32'h0, 4'hf);
      wr(A_B, 32'h1234_5678, 4'hf);
      wr(A_A, 32'hdead_beef, 4'hf);
      check("ram_readfirst_old", rdata, 32'h0);
      rd(A_A);
      check("ram_read_new", rdata, 32'hdead_beef);
      rd(A_B);
      check("b2b_b0", rdata, 32'h1234_5678);
      rd(A_A);
      check("b2b_a1", rdata, 32'hdead_beef);
      rd(A_B);
      check("b2b_b1", rdata, 32'h1234_5678);

      // MMIO
      wr(A_LED, 32'h0001_ffff, 4'hf);
      check("led_write", {16'h0, led_out}, 32'h0000_ffff);
      switch_in = 8'h5a;
      rd(A_SW);
      check("switch_read", rdata, 32'h0000_005a);
      wr(A_SW, 32'hffff_ffff, 4'hf);
      rd(A_SW);
      check("switch_ro", rdata, 32'h0000_005a);
      rd(A_LED);
      check("led_read", rdata, 32'h0000_ffff);
      wr(A_LED, 32'h0000_1200, 4'b0010);
      check("led_lane1", {16'h0, led_out}, 32'h0000_12ff);
      wr(A_NUM, 32'h8765_4321, 4'hf);
      check("num_write", num_out, 32'h8765_4321);
      wr(A_NUM, 32'h0000_00aa, 4'b0001);
      rd(A_NUM);
      check("num_merge_read", rdata, 32'h8765_43aa);

      // TIMER wrap and rate
      wr(A_TIMER, 32'hffff_fffe, 4'hf);
      idle(2);
      rd(A_TIMER);
      check("timer_wrap", rdata, 32'h0);
      rd(A_TIMER);
      t0 = rdata;
      idle(4);
      rd(A_TIMER);
      check("timer_delta5", rdata - t0, 32'd5);

      // Miss and idle hold
      rd(A_A);
      check("pre_miss", rdata, 32'hdead_beef);
      rd(32'h0000_0100);
      check("miss_read", rdata, 32'h0);
      idle(4);
      check("miss_idle_hold", rdata, 32'h0);
      wr(32'h0000_0010, 32'h5555_5555, 4'hf);
      rd(A_M);
      check("miss_write_ram", rdata, 32'h11bb_33dd);
      check("miss_write_led", {16'h0, led_out}, 32'h0000_12ff);
      check("miss_write_num", num_out, 32'h8765_43aa);

      // Hold on idle after nonzero read
      rd(A_A);
      idle(2);
      check("idle_hold", rdata, 32'hdead_beef);

      // Reset mid-stream drops the request
      resetn = 1'b0;
      wr(A_A, 32'h0, 4'hf);
      check("midreset_rdata", rdata, 32'h0);
      check("midreset_led", {16'h0, led_out}, 32'h0);
      resetn = 1'b1;
      rd(A_A);
      check("midreset_dropped_write", rdata, 32'hdead_beef);

      idle(1);
      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
